// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Hazard unit for the 5-stage pipeline, extended with a register scoreboard
// and an outstanding-operation counter so that multi-cycle units (mul/div)
// can complete out of order with the main pipe. RAW, WAW and capacity
// hazards against in-flight multi-cycle ops are resolved by stalling Decode.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   rs1_d, rs2_d, rd_d         Decode source / destination indices
//   reg_write_d, mc_d          Decode writes rd_d / is a multi-cycle op
//   rs1_e, rs2_e, rd_e         Execute indices
//   load_e, mc_e, pc_src_e     Execute is a load / issues a multi-cycle op /
//                              redirects the front end
//   rd_m, reg_write_m          Memory-stage writer
//   rd_w, reg_write_w          Writeback-stage writer
//   mc_done, mc_done_rd        multi-cycle completion strobe and destination
//   stall_f, stall_d           hold PC and F/D
//   flush_d, flush_e           bubble F/D and D/E
//   fwd_a_e, fwd_b_e           00 reg file, 10 M-stage result, 01 W-stage result
//   mc_busy                    at least one multi-cycle op outstanding
//   mc_err                     sticky protocol error
//
// Optional feature macro: HAZARD_SB_PERF_EN
//   Adds stall_cycles / flush_cycles saturating counters (CNT_W bits each).
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int MC_DEPTH = 2,
    parameter int CNT_W    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rs1_d,
    input  logic [AW-1:0] rs2_d,
    input  logic [AW-1:0] rd_d,
    input  logic          reg_write_d,
    input  logic          mc_d,
    input  logic [AW-1:0] rs1_e,
    input  logic [AW-1:0] rs2_e,
    input  logic [AW-1:0] rd_e,
    input  logic          load_e,
    input  logic          mc_e,
    input  logic          pc_src_e,
    input  logic [AW-1:0] rd_m,
    input  logic          reg_write_m,
    input  logic [AW-1:0] rd_w,
    input  logic          reg_write_w,
    input  logic          mc_done,
    input  logic [AW-1:0] mc_done_rd,
    output logic          stall_f,
    output logic          stall_d,
    output logic          flush_d,
    output logic          flush_e,
    output logic [1:0]    fwd_a_e,
    output logic [1:0]    fwd_b_e,
    output logic          mc_busy,
    output logic          mc_err
`ifdef HAZARD_SB_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles
`endif
);

    localparam int              NP      = 2 ** AW;
    localparam int              OW      = 4;  // MC_DEPTH is at most 15
    localparam logic [OW-1:0]   DEPTH_L = OW'(MC_DEPTH);
    localparam logic [AW:0]     NREG_L  = (AW + 1)'(NREG);
    localparam logic [AW-1:0]   ZERO_R  = {AW{1'b0}};
    localparam logic [NP-1:0]   ONE_HOT = {{(NP - 1){1'b0}}, 1'b1};

    logic [NP-1:0] pending_q, pending_d;
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic          mc_err_q, mc_err_d;

    logic          stall_s;
    logic [OW:0]   occupancy_s;
    logic [NP-1:0] set_mask_s, clr_mask_s;
    logic          done_bad_s, issue_bad_s;

    // Forwarding select: M beats W, x0 never forwards.
    function automatic logic [1:0] fwd_sel(input logic [AW-1:0] rs,
                                           input logic          wm,
                                           input logic [AW-1:0] rdm,
                                           input logic          ww,
                                           input logic [AW-1:0] rdw);
        logic [1:0] sel;
        if (wm && (rdm != ZERO_R) && (rdm == rs)) begin
            sel = 2'b10;
        end else if (ww && (rdw != ZERO_R) && (rdw == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // A register is busy if it is pending or is being issued to right now.
    function automatic logic hit(input logic [AW-1:0] x,
                                 input logic [NP-1:0] pend,
                                 input logic          issue,
                                 input logic [AW-1:0] issue_rd);
        return (x != ZERO_R) && (pend[x] || (issue && (issue_rd == x)));
    endfunction

    // Hazard detection and the pipeline control outputs.
    always_comb begin
        occupancy_s = {1'b0, outstanding_q} + {{OW{1'b0}}, mc_e};
        stall_s = (load_e && (rd_e != ZERO_R) && ((rd_e == rs1_d) || (rd_e == rs2_d)))
                | hit(rs1_d, pending_q, mc_e, rd_e)
                | hit(rs2_d, pending_q, mc_e, rd_e)
                | (reg_write_d && hit(rd_d, pending_q, mc_e, rd_e))
                | (mc_d && (occupancy_s >= {1'b0, DEPTH_L}));
        // A redirect squashes the Decode instruction, so it overrides the hold.
        stall_f = stall_s & ~pc_src_e;
        stall_d = stall_s & ~pc_src_e;
        flush_d = pc_src_e;
        flush_e = stall_s | pc_src_e;
        fwd_a_e = fwd_sel(rs1_e, reg_write_m, rd_m, reg_write_w, rd_w);
        fwd_b_e = fwd_sel(rs2_e, reg_write_m, rd_m, reg_write_w, rd_w);
        mc_busy = (outstanding_q != {OW{1'b0}});
        mc_err  = mc_err_q;
    end

    // Scoreboard, outstanding counter and error next-state.
    always_comb begin
        clr_mask_s = (mc_done && (mc_done_rd != ZERO_R)) ? (ONE_HOT << mc_done_rd) : {NP{1'b0}};
        set_mask_s = (mc_e && (rd_e != ZERO_R) && ({1'b0, rd_e} < NREG_L))
                   ? (ONE_HOT << rd_e) : {NP{1'b0}};
        // Clear first, then set, so a same-register issue wins over completion.
        pending_d = (pending_q & ~clr_mask_s) | set_mask_s;

        done_bad_s  = mc_done && ((outstanding_q == {OW{1'b0}})
                    || ((mc_done_rd != ZERO_R) && !pending_q[mc_done_rd]));
        issue_bad_s = mc_e && (outstanding_q == DEPTH_L);
        mc_err_d    = mc_err_q | done_bad_s | issue_bad_s;

        outstanding_d = outstanding_q;
        case ({mc_e, mc_done})
            2'b10: begin
                if (outstanding_q == DEPTH_L) begin
                    outstanding_d = outstanding_q;
                end else begin
                    outstanding_d = outstanding_q + {{(OW - 1){1'b0}}, 1'b1};
                end
            end
            2'b01: begin
                if (outstanding_q == {OW{1'b0}}) begin
                    outstanding_d = outstanding_q;
                end else begin
                    outstanding_d = outstanding_q - {{(OW - 1){1'b0}}, 1'b1};
                end
            end
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Tracking state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q     <= {NP{1'b0}};
            outstanding_q <= {OW{1'b0}};
            mc_err_q      <= 1'b0;
        end else begin
            pending_q     <= pending_d;
            outstanding_q <= outstanding_d;
            mc_err_q      <= mc_err_d;
        end
    end

`ifdef HAZARD_SB_PERF_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_cycles_q, flush_cycles_d;

    // Saturating perf counter next-state.
    always_comb begin
        if (stall_d && !(&stall_cycles_q)) begin
            stall_cycles_d = stall_cycles_q + {{(CNT_W - 1){1'b0}}, 1'b1};
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
        if (flush_d && !(&flush_cycles_q)) begin
            flush_cycles_d = flush_cycles_q + {{(CNT_W - 1){1'b0}}, 1'b1};
        end else begin
            flush_cycles_d = flush_cycles_q;
        end
    end

    // Perf counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= {CNT_W{1'b0}};
            flush_cycles_q <= {CNT_W{1'b0}};
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_cycles_q <= flush_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_cycles = flush_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    localparam int AW       = 5;
    localparam int MC_DEPTH = 2;
    localparam int CNT_W    = 32;

    logic clk = 1'b0;
    logic rst;
    logic [AW-1:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, mc_done_rd;
    logic reg_write_d, mc_d, load_e, mc_e, pc_src_e, reg_write_m, reg_write_w, mc_done;
    logic stall_f, stall_d, flush_d, flush_e, mc_busy, mc_err;
    logic [1:0] fwd_a_e, fwd_b_e;
`ifdef HAZARD_SB_PERF_EN
    logic [CNT_W-1:0] stall_cycles, flush_cycles;
`endif

    int tests = 0;
    int failures = 0;

    // Reference model: in-flight multi-cycle ops as a list of destinations.
    int q[$];
    bit m_err;

    always #5 clk = ~clk;

    hazard_scoreboard #(.NREG(32), .AW(AW), .MC_DEPTH(MC_DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .reg_write_d(reg_write_d), .mc_d(mc_d),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .load_e(load_e), .mc_e(mc_e), .pc_src_e(pc_src_e),
        .rd_m(rd_m), .reg_write_m(reg_write_m),
        .rd_w(rd_w), .reg_write_w(reg_write_w),
        .mc_done(mc_done), .mc_done_rd(mc_done_rd),
        .stall_f(stall_f), .stall_d(stall_d),
        .flush_d(flush_d), .flush_e(flush_e),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
        .mc_busy(mc_busy), .mc_err(mc_err)
`ifdef HAZARD_SB_PERF_EN
        , .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        {rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, mc_done_rd} = '0;
        {reg_write_d, mc_d, load_e, mc_e, pc_src_e, reg_write_m, reg_write_w, mc_done} = '0;
    endtask

    function automatic bit pend(int x);
        if (x == 0) return 1'b0;
        foreach (q[i]) if (q[i] == x) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit hitm(int x);
        return (x != 0) && (pend(x) || (mc_e && int'(rd_e) == x));
    endfunction

    function automatic logic [1:0] fwd(int rs);
        if (reg_write_m && rd_m != 0 && int'(rd_m) == rs) return 2'b10;
        if (reg_write_w && rd_w != 0 && int'(rd_w) == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [9:0] expected();
        bit st;
        st = (load_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d))
           || hitm(int'(rs1_d)) || hitm(int'(rs2_d))
           || (reg_write_d && hitm(int'(rd_d)))
           || (mc_d && (q.size() + int'(mc_e) >= MC_DEPTH));
        return {st && !pc_src_e, st && !pc_src_e, pc_src_e, st || pc_src_e,
                fwd(int'(rs1_e)), fwd(int'(rs2_e)), q.size() != 0, m_err};
    endfunction

    task automatic model_step();
        if (mc_done && q.size() == 0) m_err = 1'b1;
        if (mc_done && mc_done_rd != 0 && !pend(int'(mc_done_rd))) m_err = 1'b1;
        if (mc_e && q.size() == MC_DEPTH) m_err = 1'b1;
        if (mc_done) begin
            for (int i = 0; i < q.size(); i++) begin
                if (q[i] == int'(mc_done_rd)) begin
                    q.delete(i);
                    break;
                end
            end
        end
        if (mc_e && q.size() < MC_DEPTH) q.push_back(int'(rd_e));
    endtask

    initial begin
        int cand;
        clear_inputs();
        rst = 1'b1;
        #1;
        check("rst_outs", 32'({stall_f, stall_d, flush_d, flush_e, fwd_a_e, fwd_b_e, mc_busy, mc_err}), 32'd0);
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        check("post_rst", 32'({mc_busy, mc_err}), 32'd0);

        // Forwarding priority
        rd_m = 5'd5; rd_w = 5'd5; rs1_e = 5'd5; reg_write_m = 1'b1; reg_write_w = 1'b1;
        #1 check("fwd_a_m", 32'(fwd_a_e), 32'h2);
        reg_write_m = 1'b0;
        #1 check("fwd_a_w", 32'(fwd_a_e), 32'h1);
        rs1_e = 5'd0;
        #1 check("fwd_a_x0", 32'(fwd_a_e), 32'h0);
        reg_write_m = 1'b1; rs2_e = 5'd5;
        #1 check("fwd_b_m", 32'(fwd_b_e), 32'h2);
        clear_inputs();

        // Load-use
        load_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7;
        #1 check("ld_use", 32'({stall_f, stall_d, flush_e}), 32'h7);
        cyc();
        load_e = 1'b0;
        #1 check("ld_use_rel", 32'({stall_f, stall_d, flush_e}), 32'h0);
        clear_inputs();

        // Scoreboard RAW / WAW on x9
        mc_e = 1'b1; rd_e = 5'd9; rs1_d = 5'd9;
        #1 check("raw_issue", 32'(stall_d), 32'd1);
        cyc();
        mc_e = 1'b0; rd_e = 5'd0;
        #1 check("raw_pend", 32'({stall_d, mc_busy}), 32'h3);
        cyc();
        check("raw_hold", 32'(stall_d), 32'd1);
        rs1_d = 5'd0; reg_write_d = 1'b1; rd_d = 5'd9;
        #1 check("waw", 32'(stall_d), 32'd1);
        rd_d = 5'd0;
        #1 check("waw_none", 32'(stall_d), 32'd0);
        reg_write_d = 1'b0; rs1_d = 5'd9; mc_done = 1'b1; mc_done_rd = 5'd9;
        #1 check("raw_done_cyc", 32'(stall_d), 32'd1);
        cyc();
        mc_done = 1'b0;
        #1 check("raw_release", 32'({stall_d, mc_busy, mc_err}), 32'h0);
        clear_inputs();

        // Capacity
        mc_e = 1'b1; rd_e = 5'd3;
        cyc();
        rd_e = 5'd4;
        cyc();
        mc_e = 1'b0; rd_e = 5'd0; mc_d = 1'b1;
        #1 check("cap_full", 32'(stall_d), 32'd1);
        mc_done = 1'b1; mc_done_rd = 5'd3;
        #1 check("cap_conservative", 32'(stall_d), 32'd1);
        cyc();
        mc_done = 1'b0;
        #1 check("cap_release", 32'({stall_d, mc_busy}), 32'h1);

        // Redirect beats scoreboard stall
        rs1_d = 5'd4; pc_src_e = 1'b1;
        #1 check("redirect", 32'({stall_f, stall_d, flush_d, flush_e}), 32'h3);
        pc_src_e = 1'b0; rs1_d = 5'd0; mc_d = 1'b0; mc_done = 1'b1; mc_done_rd = 5'd4;
        cyc();
        mc_done = 1'b0;
        #1 check("cap_idle", 32'({mc_busy, mc_err}), 32'h0);

        // Errors and reset
        mc_done = 1'b1; mc_done_rd = 5'd0;
        cyc();
        mc_done = 1'b0;
        #1 check("err_underflow", 32'({mc_busy, mc_err}), 32'h1);
        mc_e = 1'b1; rd_e = 5'd12;
        cyc();
        mc_e = 1'b0; rd_e = 5'd0;
        #1 check("err_sticky", 32'({mc_busy, mc_err}), 32'h3);
        rst = 1'b1;
        cyc();
        rst = 1'b0; rs1_d = 5'd12;
        #1 check("rst_clears", 32'({stall_d, mc_busy, mc_err}), 32'h0);
        clear_inputs();
`ifdef HAZARD_SB_PERF_EN
        check("perf_rst", 32'(stall_cycles) | 32'(flush_cycles), 32'd0);
        load_e = 1'b1; rd_e = 5'd7; rs1_d = 5'd7;
        cyc(); cyc(); cyc();
        clear_inputs();
        pc_src_e = 1'b1;
        cyc(); cyc();
        pc_src_e = 1'b0;
        #1 check("perf_stall", 32'(stall_cycles), 32'd3);
        check("perf_flush", 32'(flush_cycles), 32'd2);
`endif

        // Randomized run against the reference model
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        q.delete();
        m_err = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            rs1_d = 5'($urandom_range(0, 15)); rs2_d = 5'($urandom_range(0, 15));
            rd_d  = 5'($urandom_range(0, 15)); reg_write_d = 1'($urandom_range(0, 1));
            mc_d  = 1'($urandom_range(0, 1));  load_e = ($urandom_range(0, 3) == 0);
            rs1_e = 5'($urandom_range(0, 7));  rs2_e = 5'($urandom_range(0, 7));
            rd_m  = 5'($urandom_range(0, 7));  reg_write_m = 1'($urandom_range(0, 1));
            rd_w  = 5'($urandom_range(0, 7));  reg_write_w = 1'($urandom_range(0, 1));
            pc_src_e = ($urandom_range(0, 7) == 0);
            mc_done = 1'b0; mc_done_rd = 5'($urandom_range(0, 15));
            if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
                mc_done = 1'b1;
                mc_done_rd = 5'(q[$urandom_range(0, q.size() - 1)]);
            end
            mc_e = 1'b0; rd_e = 5'($urandom_range(0, 15));
            if (q.size() < MC_DEPTH && $urandom_range(0, 2) == 0) begin
                cand = 0;
                for (int t = 0; t < 8; t++) begin
                    cand = int'($urandom_range(0, 15));
                    if (!pend(cand)) break;
                end
                if (pend(cand)) cand = 0;
                mc_e = 1'b1;
                rd_e = 5'(cand);
            end
            #1 check("rand", 32'({stall_f, stall_d, flush_d, flush_e, fwd_a_e, fwd_b_e, mc_busy, mc_err}),
                     32'(expected()));
            model_step();
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
